// File: rtl/uart_mmio_if.sv
// Memory-mapped bus between the memory controller and the UART window.
// The controller drives strobes, offset and write data; the UART returns read data.
interface uart_mmio_if;
  logic       tx_wen;
  logic       rx_ren;
  logic [2:0] uart_addr;
  logic [7:0] uart_din;
  logic [7:0] uart_dout;

  modport master (output tx_wen, rx_ren, uart_addr, uart_din, input uart_dout);
  modport slave  (input tx_wen, rx_ren, uart_addr, uart_din, output uart_dout);
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX/RX byte FIFOs, serial transmitter and receiver.
// Offset 0 = data (write pushes TX, read shows RX head, rx_ren pops).
// Offset 4 = status {4'b0, frame_err, rx_overrun, tx_full, rx_data_present};
// writing bit 2 / bit 3 clears rx_overrun / frame_err.
//
// TX and RX FSM states:
//   state   | meaning
//   S_IDLE  | line idle; TX waits for FIFO data, RX waits for synchronized rxd=0
//   S_START | start bit; TX drives 0, RX waits to mid-bit and rejects glitches
//   S_DATA  | 8 data bits, LSB first
//   S_STOP  | stop bit; TX drives 1, RX samples and pushes/flags the byte
module uart_mmio #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  uart_mmio_if.slave bus,
  output logic       tx_full,
  output logic       rx_data_present,
  output logic       txd,
  input  logic       rxd
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // Bus decode
  logic sel_data, sel_ctl, ctl_wr;
  assign sel_data = (bus.uart_addr == 3'd0);
  assign sel_ctl  = (bus.uart_addr == 3'd4);
  assign ctl_wr   = bus.tx_wen & sel_ctl;

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_rptr_q;
  logic [AW:0]   tx_cnt_q, tx_cnt_d;
  logic          tx_push, tx_pop;
  logic [7:0]    tx_head;

  // A pop in the same cycle makes room, so a push to a full FIFO still lands.
  assign tx_full = (tx_cnt_q == DEPTH_C);
  assign tx_push = bus.tx_wen & sel_data & (~tx_full | tx_pop);
  assign tx_head = tx_mem_q[tx_rptr_q];

  // TX occupancy next-state
  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + (AW+1)'(1);
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - (AW+1)'(1);
  end

  // TX storage; contents need no reset, pointers and count decide validity
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= bus.uart_din;
  end

  // TX pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + AW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + AW'(1);
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // ---------------- TX FSM ----------------
  state_e      tx_state_q;
  logic [15:0] tx_tmr_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        txd_q;

  // Load the next byte from IDLE, or straight from the end of STOP so frames run back-to-back.
  assign tx_pop = (tx_cnt_q != '0) &&
                  ((tx_state_q == S_IDLE) || ((tx_state_q == S_STOP) && (tx_tmr_q == '0)));
  assign txd    = txd_q;

  // Transmit sequencer with registered line output; reset forces the line high at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= S_IDLE;
      tx_tmr_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          if (tx_pop) begin
            tx_state_q <= S_START;
            tx_shift_q <= tx_head;
            tx_tmr_q   <= BIT_LAST;
            txd_q      <= 1'b0;
          end
        end
        S_START: begin
          if (tx_tmr_q == '0) begin
            tx_state_q <= S_DATA;
            tx_tmr_q   <= BIT_LAST;
            tx_bit_q   <= '0;
            txd_q      <= tx_shift_q[0];
          end else begin
            tx_tmr_q <= tx_tmr_q - 16'd1;
          end
        end
        S_DATA: begin
          if (tx_tmr_q == '0) begin
            tx_tmr_q <= BIT_LAST;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= S_STOP;
              txd_q      <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              txd_q      <= tx_shift_q[1];
            end
          end else begin
            tx_tmr_q <= tx_tmr_q - 16'd1;
          end
        end
        S_STOP: begin
          if (tx_tmr_q == '0) begin
            if (tx_pop) begin
              tx_state_q <= S_START;
              tx_shift_q <= tx_head;
              tx_tmr_q   <= BIT_LAST;
              txd_q      <= 1'b0;
            end else begin
              tx_state_q <= S_IDLE;
            end
          end else begin
            tx_tmr_q <= tx_tmr_q - 16'd1;
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX synchronizer ----------------
  logic rxd_s1_q, rxd_s2_q;

  // Two-flop synchronizer; resets to idle-high so nothing starts until a real low is seen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
    end else begin
      rxd_s1_q <= rxd;
      rxd_s2_q <= rxd_s1_q;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] rx_wptr_q, rx_rptr_q;
  logic [AW:0]   rx_cnt_q, rx_cnt_d;
  logic          rx_full, rx_push, rx_pop, rx_stop_evt;
  logic [7:0]    rx_shift_q;
  state_e        rx_state_q;
  logic [15:0]   rx_tmr_q;
  logic [2:0]    rx_bit_q;

  assign rx_full         = (rx_cnt_q == DEPTH_C);
  assign rx_data_present = (rx_cnt_q != '0);
  assign rx_pop          = bus.rx_ren & sel_data & rx_data_present;
  assign rx_stop_evt     = (rx_state_q == S_STOP) && (rx_tmr_q == '0);
  assign rx_push         = rx_stop_evt & rxd_s2_q & (~rx_full | rx_pop);

  // RX occupancy next-state
  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + (AW+1)'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - (AW+1)'(1);
  end

  // RX storage
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_shift_q;
  end

  // RX pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + AW'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + AW'(1);
      rx_cnt_q <= rx_cnt_d;
    end
  end

  // ---------------- RX FSM ----------------
  // Receive sequencer: mid-bit sampling timed from the synchronized falling edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= S_IDLE;
      rx_tmr_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      case (rx_state_q)
        S_IDLE: begin
          if (!rxd_s2_q) begin
            rx_state_q <= S_START;
            rx_tmr_q   <= HALF_LAST;
          end
        end
        S_START: begin
          if (rx_tmr_q == '0) begin
            if (rxd_s2_q) begin
              rx_state_q <= S_IDLE;
            end else begin
              rx_state_q <= S_DATA;
              rx_tmr_q   <= BIT_LAST;
              rx_bit_q   <= '0;
            end
          end else begin
            rx_tmr_q <= rx_tmr_q - 16'd1;
          end
        end
        S_DATA: begin
          if (rx_tmr_q == '0) begin
            rx_shift_q <= {rxd_s2_q, rx_shift_q[7:1]};
            rx_tmr_q   <= BIT_LAST;
            if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_tmr_q <= rx_tmr_q - 16'd1;
          end
        end
        S_STOP: begin
          if (rx_tmr_q == '0) rx_state_q <= S_IDLE;
          else                rx_tmr_q   <= rx_tmr_q - 16'd1;
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- Status flags ----------------
  logic rx_overrun_q, frame_err_q;
  logic ovr_set, ferr_set;

  assign ovr_set  = rx_stop_evt & rxd_s2_q & rx_full & ~rx_pop;
  assign ferr_set = rx_stop_evt & ~rxd_s2_q;

  // Sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_overrun_q <= (rx_overrun_q & ~(ctl_wr & bus.uart_din[2])) | ovr_set;
      frame_err_q  <= (frame_err_q  & ~(ctl_wr & bus.uart_din[3])) | ferr_set;
    end
  end

  // ---------------- Read mux ----------------
  logic [7:0] dout;

  // Read data valid in the strobe cycle; empty RX FIFO reads as zero
  always_comb begin
    dout = 8'h00;
    if (sel_data && rx_data_present) dout = rx_mem_q[rx_rptr_q];
    else if (sel_ctl)                dout = {4'b0, frame_err_q, rx_overrun_q, tx_full, rx_data_present};
  end

  assign bus.uart_dout = dout;

endmodule
